// File: rtl/wrep_pkg.sv
// Shared types and helpers for the weight stream repeater.
package wrep_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        REPLAY = 1'b1
    } wrep_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrep_buf.sv
// Register-file weight buffer: one synchronous write port, one combinational read port.
module wrep_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage carries no reset; every entry is written during LOAD before REPLAY reads it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/weight_stream_repeater.sv
// Captures one BDIM-beat weight block and replays it SDIM times on a valid/ready stream.
// Optional macro WREP_TLAST_EN adds m_axis_weights_tlast marking the last beat of each replay.
module weight_stream_repeater
    import wrep_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 8,
    parameter int BDIM         = 32,
    parameter int SDIM         = 4
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [WEIGHT_WIDTH-1:0] s_axis_weights_in_tdata,
    input  logic                    s_axis_weights_in_tvalid,
    output logic                    s_axis_weights_in_tready,
    output logic [WEIGHT_WIDTH-1:0] m_axis_weights_tdata,
    output logic                    m_axis_weights_tvalid,
    input  logic                    m_axis_weights_tready,
`ifdef WREP_TLAST_EN
    output logic                    m_axis_weights_tlast,
`endif
    output logic                    busy,
    output logic                    block_done
);

    localparam int IW = cnt_w(BDIM);
    localparam int RW = cnt_w(SDIM);
    localparam logic [IW-1:0] IDX_LAST = IW'(BDIM - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(SDIM - 1);

    if (BDIM < 1 || SDIM < 1) begin : g_param_check
        $error("weight_stream_repeater: BDIM and SDIM must both be >= 1");
    end

    wrep_state_e   state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          done_q, done_d;

    logic in_fire;
    logic out_fire;

    // tready is held low during reset itself, not only in the state after it.
    assign s_axis_weights_in_tready = (state_q == LOAD) && !ap_rst;
    assign m_axis_weights_tvalid    = (state_q == REPLAY);
    assign busy                     = (state_q == REPLAY);
    assign block_done               = done_q;
`ifdef WREP_TLAST_EN
    assign m_axis_weights_tlast     = (state_q == REPLAY) && (rd_idx_q == IDX_LAST);
`endif

    assign in_fire  = s_axis_weights_in_tvalid && s_axis_weights_in_tready;
    assign out_fire = m_axis_weights_tvalid && m_axis_weights_tready;

    wrep_buf #(
        .WIDTH (WEIGHT_WIDTH),
        .DEPTH (BDIM),
        .AW    (IW)
    ) u_buf (
        .clk_i   (ap_clk),
        .we_i    (in_fire),
        .waddr_i (wr_idx_q),
        .wdata_i (s_axis_weights_in_tdata),
        .raddr_i (rd_idx_q),
        .rdata_o (m_axis_weights_tdata)
    );

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        rep_cnt_d = rep_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (in_fire) begin
                    if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d  = '0;
                        rd_idx_d  = '0;
                        rep_cnt_d = '0;
                        state_d   = REPLAY;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            REPLAY: begin
                if (out_fire) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d = '0;
                        if (rep_cnt_q == REP_LAST) begin
                            rep_cnt_d = '0;
                            state_d   = LOAD;
                            done_d    = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= LOAD;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            rep_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            rep_cnt_q <= rep_cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_weight_stream_repeater.sv
// Self-checking bench: a BDIM=4/SDIM=3 instance plus a degenerate BDIM=1/SDIM=1 instance.
module tb_weight_stream_repeater;

    localparam int W = 8;
    localparam int B = 4;
    localparam int S = 3;

    typedef logic [W-1:0] blk_t [B];

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    logic [W-1:0] a_in_tdata, a_tdata, b_in_tdata, b_tdata;
    logic a_in_tvalid, a_in_tready, a_tvalid, a_out_tready, a_busy, a_block_done;
    logic b_in_tvalid, b_in_tready, b_tvalid, b_out_tready, b_busy, b_block_done;
`ifdef WREP_TLAST_EN
    logic a_tlast, b_tlast;
`endif

    weight_stream_repeater #(.WEIGHT_WIDTH(W), .BDIM(B), .SDIM(S)) dut_a (
        .ap_clk                   (ap_clk),
        .ap_rst                   (ap_rst),
        .s_axis_weights_in_tdata  (a_in_tdata),
        .s_axis_weights_in_tvalid (a_in_tvalid),
        .s_axis_weights_in_tready (a_in_tready),
        .m_axis_weights_tdata     (a_tdata),
        .m_axis_weights_tvalid    (a_tvalid),
        .m_axis_weights_tready    (a_out_tready),
`ifdef WREP_TLAST_EN
        .m_axis_weights_tlast     (a_tlast),
`endif
        .busy                     (a_busy),
        .block_done               (a_block_done)
    );

    weight_stream_repeater #(.WEIGHT_WIDTH(W), .BDIM(1), .SDIM(1)) dut_b (
        .ap_clk                   (ap_clk),
        .ap_rst                   (ap_rst),
        .s_axis_weights_in_tdata  (b_in_tdata),
        .s_axis_weights_in_tvalid (b_in_tvalid),
        .s_axis_weights_in_tready (b_in_tready),
        .m_axis_weights_tdata     (b_tdata),
        .m_axis_weights_tvalid    (b_tvalid),
        .m_axis_weights_tready    (b_out_tready),
`ifdef WREP_TLAST_EN
        .m_axis_weights_tlast     (b_tlast),
`endif
        .busy                     (b_busy),
        .block_done               (b_block_done)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Feeds one block, then queues the S-fold replay the consumer must see.
    task automatic load_block(input blk_t blk);
        for (int i = 0; i < B; i++) begin
            a_in_tvalid = 1'b1;
            a_in_tdata  = blk[i];
            check("load_tready", a_in_tready, 1);
            check("load_no_valid", a_tvalid, 0);
            step();
        end
        a_in_tvalid = 1'b0;
        for (int r = 0; r < S; r++)
            for (int i = 0; i < B; i++)
                exp_q.push_back(blk[i]);
        check("first_beat_latency", a_tvalid, 1);
    endtask

    // Drains the queued replay; returns at the block_done cycle (or after stop_after beats).
    task automatic run_replay(input int ready_pct, input bit hold_aa, input int stop_after,
                              output int last_cyc);
        int beats = 0;
        bit done_pend = 0, stalled = 0, finished = 0;
        logic [W-1:0] prev = '0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a_out_tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
            if (hold_aa) begin
                a_in_tvalid = 1'b1;
                a_in_tdata  = 8'hAA;
            end
            check("block_done", a_block_done, done_pend);
            if (done_pend) begin
                check("load_reentry_tready", a_in_tready, 1);
                check("idle_after_done", a_tvalid, 0);
                check("busy_after_done", a_busy, 0);
                finished = 1;
                break;
            end
            check("tvalid", a_tvalid, 1);
            check("busy", a_busy, 1);
            check("in_blocked", a_in_tready, 0);
            if (stalled) check("stall_stable", a_tdata, prev);
`ifdef WREP_TLAST_EN
            check("tlast", a_tlast, (beats % B) == B - 1);
`endif
            if (a_out_tready) begin
                check("tdata", a_tdata, exp_q.pop_front());
                beats++;
                stalled = 0;
                if (beats == B * S) begin
                    done_pend = 1;
                    last_cyc  = cyc;
                end
            end else begin
                stalled = 1;
                prev    = a_tdata;
            end
            if (stop_after > 0 && beats == stop_after) begin
                finished = 1;
                break;
            end
            step();
        end
        if (!finished) check("replay_timeout", 0, 1);
    endtask

    initial begin
        blk_t blk;
        int   last_cyc;
        logic [W-1:0] d;

        a_in_tdata = '0; a_in_tvalid = 1'b0; a_out_tready = 1'b0;
        b_in_tdata = '0; b_in_tvalid = 1'b0; b_out_tready = 1'b0;

        #12;
        check("rst_tvalid", a_tvalid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_block_done", a_block_done, 0);
        check("rst_in_tready", a_in_tready, 0);
        check("rst_b_tvalid", b_tvalid, 0);
`ifdef WREP_TLAST_EN
        check("rst_tlast", a_tlast, 0);
`endif
        ap_rst = 1'b0;
        step();
        check("post_rst_in_tready", a_in_tready, 1);

        // Basic replay with the consumer always ready.
        blk = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_block(blk);
        run_replay(100, 1'b0, 0, last_cyc);
        check("consecutive_beats", last_cyc, B * S - 1);

        // Same block under 50% backpressure, then random blocks.
        step();
        load_block(blk);
        run_replay(50, 1'b0, 0, last_cyc);
        for (int n = 0; n < 3; n++) begin
            step();
            for (int i = 0; i < B; i++) blk[i] = W'($urandom);
            load_block(blk);
            run_replay(30 + 20 * n, 1'b0, 0, last_cyc);
        end

        // Input held valid with 0xAA through replay; it opens the next block.
        step();
        for (int i = 0; i < B; i++) blk[i] = W'($urandom);
        load_block(blk);
        run_replay(60, 1'b1, 0, last_cyc);
        blk[0] = 8'hAA;
        for (int i = 1; i < B; i++) blk[i] = W'($urandom);
        load_block(blk);
        run_replay(100, 1'b0, 0, last_cyc);

        // Async reset while beat 6 is presented.
        step();
        for (int i = 0; i < B; i++) blk[i] = W'($urandom);
        load_block(blk);
        run_replay(100, 1'b0, 5, last_cyc);
        step();
        check("beat6_valid", a_tvalid, 1);
        #2 ap_rst = 1'b1;
        #1;
        check("async_rst_tvalid", a_tvalid, 0);
        check("async_rst_busy", a_busy, 0);
        check("async_rst_in_tready", a_in_tready, 0);
        exp_q.delete();
        @(posedge ap_clk);
        #3 ap_rst = 1'b0;
        step();
        check("after_rst_tvalid", a_tvalid, 0);
        check("after_rst_block_done", a_block_done, 0);
        blk = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_block(blk);
        run_replay(100, 1'b0, 0, last_cyc);
        check("after_rst_consecutive", last_cyc, B * S - 1);

        // Degenerate BDIM=1, SDIM=1: store-and-forward of one beat.
        step();
        for (int n = 0; n < 3; n++) begin
            d = (n == 0) ? 8'h5A : W'($urandom);
            b_in_tvalid = 1'b1; b_in_tdata = d; b_out_tready = 1'b1;
            check("b_in_tready", b_in_tready, 1);
            check("b_idle_busy", b_busy, 0);
            step();
            b_in_tvalid = 1'b0;
            check("b_tvalid", b_tvalid, 1);
            check("b_tdata", b_tdata, d);
            check("b_busy", b_busy, 1);
`ifdef WREP_TLAST_EN
            check("b_tlast", b_tlast, 1);
`endif
            step();
            check("b_done_tvalid", b_tvalid, 0);
            check("b_done_busy", b_busy, 0);
            check("b_block_done", b_block_done, 1);
            check("b_done_in_tready", b_in_tready, 1);
            step();
            check("b_block_done_clear", b_block_done, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/weight_stream_repeater.md
Name: weight_stream_repeater

Overview:
- Upstream feeder for the MAC stage's WEIGHT stream interface (s_axis_weights).
- Captures one BDIM-element weight block from a DMA/AXI-Stream source into a local buffer.
- Replays the block SDIM times on its output stream, so the MAC sees weights re-streamed once per input block.
- Frees the DMA from re-fetching weights; the consumer sees a standard valid/ready stream.

Parameters:
- WEIGHT_WIDTH, 8: bits per weight beat; must match the consumer's weight tdata width.
- BDIM, 32: beats per weight block; >=1.
- SDIM, 4: number of replays of each block; >=1.
- BDIM<1 or SDIM<1 is an elaboration error ($error in an initial/generate check).

Ports:
- ap_clk  in  1  clock; all logic on its rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- s_axis_weights_in_tdata  in  WEIGHT_WIDTH  weight beat from source.
- s_axis_weights_in_tvalid  in  1  source valid.
- s_axis_weights_in_tready  out  1  block ready to accept.
- m_axis_weights_tdata  out  WEIGHT_WIDTH  replayed weight beat.
- m_axis_weights_tvalid  out  1  output valid.
- m_axis_weights_tready  in  1  consumer ready.
- busy  out  1  high while in REPLAY.
- block_done  out  1  one-cycle pulse after the final beat of the final replay is accepted.

Behaviour:
- Clock/reset: single clock ap_clk. ap_rst is asynchronous and active-high. All state/counter flops use async reset; buffer contents are not reset.
- Reset values:
  - state=LOAD, wr_idx=0, rd_idx=0, rep_cnt=0.
  - m_axis_weights_tvalid=0, busy=0, block_done=0.
  - s_axis_weights_in_tready=0 while ap_rst is asserted.
- Counter widths: wr_idx and rd_idx are max(1,$clog2(BDIM)) bits; rep_cnt is max(1,$clog2(SDIM)) bits. No counter ever exceeds its terminal value.
- State LOAD:
  - s_axis_weights_in_tready=1 and m_axis_weights_tvalid=0.
  - Each accepted beat (tvalid&&tready) writes buf[wr_idx], then wr_idx increments.
  - When the beat accepted has wr_idx==BDIM-1: wr_idx->0, rd_idx->0, rep_cnt->0, state->REPLAY.
- State REPLAY:
  - s_axis_weights_in_tready=0.
  - m_axis_weights_tvalid=1 and m_axis_weights_tdata=buf[rd_idx]; busy=1.
  - On each accepted output beat, rd_idx increments.
  - At rd_idx==BDIM-1, rd_idx wraps to 0 and rep_cnt increments.
  - When rd_idx==BDIM-1 and rep_cnt==SDIM-1 are both true on an accepted beat: state->LOAD and block_done=1 for the next cycle.
- Latency: first output beat is valid the cycle after the last input beat is accepted. Steady-state throughput is 1 beat/cycle when m_axis_weights_tready is held high.
- Handshake:
  - tdata/tvalid stay stable while tvalid&&!tready.
  - No combinational path from m_axis_weights_tready to m_axis_weights_tvalid or tdata.
- Load/replay overlap: input is never accepted in REPLAY, so simultaneous load and replay is impossible by construction.
- Degenerate sizes: BDIM=1 replays a single beat SDIM times. SDIM=1 makes the block a store-and-forward buffer.
- Back-to-back blocks: LOAD re-entry accepts a new beat in the same cycle block_done is high.
- Reset mid-replay: the remaining beats are discarded, the FSM returns to LOAD, and tvalid drops immediately (async).

Optional Feature:
- Macro: WREP_TLAST_EN.
- Defined: adds output port m_axis_weights_tlast (1 bit, reset 0). It is asserted with the beat rd_idx==BDIM-1 of every replay, so the consumer can frame each block.
- Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Package wrep_pkg holds:
  - state enum {LOAD, REPLAY};
  - function cnt_w(n), returning max(1,$clog2(n)).
- Sub-module wrep_buf: a parameterised register-file buffer with one synchronous write port and a combinational read port, sized BDIM x WEIGHT_WIDTH, without reset.

Test Plan:
- Basic replay (BDIM=4, SDIM=3): load 0x11,0x22,0x33,0x44 with tready held 1 -> output 11,22,33,44 three times, 12 beats in consecutive cycles. block_done pulses once, in the cycle after beat 12.
- Backpressure: toggle m_axis_weights_tready at 50% on the same load -> same 12-beat order, tdata stable whenever stalled, no beats dropped or duplicated.
- Input blocked during replay: drive s_axis_weights_in_tvalid=1 with 0xAA throughout replay -> tready stays 0. 0xAA is first accepted the cycle block_done=1 and becomes the first beat of the next block.
- Degenerate BDIM=1, SDIM=1: load 0x5A -> a single output beat 0x5A, then back to LOAD, with busy high for exactly that beat.
- Async reset mid-replay: assert ap_rst during beat 6 of 12 -> tvalid drops without waiting for ap_clk. After release, load 0x01..0x04 -> replay starts at 0x01 with rep_cnt from 0.
- WREP_TLAST_EN defined: basic-replay stimulus -> tlast high on output beats 4, 8 and 12 only.
